spi_byte_slave: RTL and testbench

SPI_BYTE_SLAVE -- requirements
Module: spi_byte_slave

---
 rtl/spi_byte_slave.sv | 184 ++++++++++++++++++
 tb/tb_spi_byte_slave.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_slave.sv
// -----------------------------------------------------------------------------
// spi_byte_slave
//
// SPI mode 0 (CPOL=0, CPHA=0, MSB first, 8-bit frames) byte receiver running
// entirely in the clk_i domain. sclk_i, cs_ni and mosi_i are synchronized and
// sclk edges are found by comparing the synchronized value with a delayed copy,
// so sclk must run at no more than clk_i/4.
//
// Optional feature: define SPI_SLAVE_MISO_EN to build the MISO transmitter.
// Without it miso_o is tied low and tx_data_i is not used.
//
// Parameters
//   SYNC_STAGES : synchronizer depth on sclk_i / cs_ni / mosi_i (legal 2..3)
//
// Ports
//   clk_i      : system clock, rising-edge active
//   rst_ni     : asynchronous active-low reset
//   sclk_i     : SPI serial clock from master (asynchronous)
//   cs_ni      : SPI chip select, active-low (asynchronous)
//   mosi_i     : master-out serial data (asynchronous)
//   miso_o     : slave-out serial data (low while deselected)
//   tx_data_i  : byte returned to master on MISO
//   data_o     : last completely received byte
//   ack_o      : one-cycle strobe marking data_o updated
// -----------------------------------------------------------------------------
module spi_byte_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sclk_i,
    input  logic       cs_ni,
    input  logic       mosi_i,
    output logic       miso_o,
    input  logic [7:0] tx_data_i,
    output logic [7:0] data_o,
    output logic       ack_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sclk_d_r;

    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_rise_s;
    logic                   sclk_fall_s;

    state_e                 state_r;
    logic [2:0]             bit_cnt_r;
    logic [7:0]             shift_r;
    logic [7:0]             data_r;
    logic                   ack_r;

    // Synchronizer chains; reset values match an idle, deselected bus.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            sclk_d_r    <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk_i};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs_ni};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi_i};
            sclk_d_r    <= sclk_sync_r[SYNC_STAGES-1];
        end
    end

    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign cs_s        = cs_sync_r[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_d_r;
    assign sclk_fall_s = ~sclk_s & sclk_d_r;

    // Receive FSM: shifts MOSI on sclk rises and publishes each completed byte.
    // The rise handling comes before the deselect handling so that a byte whose
    // 8th edge coincides with cs_n rising still completes; a partial byte is
    // then cleared by the later assignments.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            data_r    <= 8'h00;
            ack_r     <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    bit_cnt_r <= 3'd0;
                    shift_r   <= 8'h00;
                    if (!cs_s) begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise_s) begin
                        shift_r   <= {shift_r[6:0], mosi_s};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            data_r <= {shift_r[6:0], mosi_s};
                            ack_r  <= 1'b1;
                        end
                    end
                    if (cs_s) begin
                        state_r   <= ST_IDLE;
                        bit_cnt_r <= 3'd0;
                        shift_r   <= 8'h00;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bit_cnt_r <= 3'd0;
                    shift_r   <= 8'h00;
                end
            endcase
        end
    end

    assign data_o = data_r;
    assign ack_o  = ack_r;

`ifdef SPI_SLAVE_MISO_EN
    logic [7:0] tx_shift_r;
    logic       rose_r;     // a rise has been seen in the current byte

    // TX shifter: loaded at frame start and at every byte wrap, shifted on the
    // falling edge after each non-final rise. Cleared while deselected so its
    // MSB doubles as the registered, low-when-idle miso_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_shift_r <= 8'h00;
            rose_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rose_r <= 1'b0;
                    if (!cs_s) begin
                        tx_shift_r <= tx_data_i;
                    end else begin
                        tx_shift_r <= 8'h00;
                    end
                end
                ST_SHIFT: begin
                    if (cs_s) begin
                        tx_shift_r <= 8'h00;
                        rose_r     <= 1'b0;
                    end else if (sclk_rise_s) begin
                        if (bit_cnt_r == 3'd7) begin
                            tx_shift_r <= tx_data_i;
                            rose_r     <= 1'b0;
                        end else begin
                            rose_r <= 1'b1;
                        end
                    end else if (sclk_fall_s && rose_r) begin
                        tx_shift_r <= {tx_shift_r[6:0], 1'b0};
                        rose_r     <= 1'b0;
                    end
                end
                default: begin
                    tx_shift_r <= 8'h00;
                    rose_r     <= 1'b0;
                end
            endcase
        end
    end

    assign miso_o = tx_shift_r[7];
`else
    logic unused_tx_s;

    assign unused_tx_s = ^tx_data_i;
    assign miso_o      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_byte_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_byte_slave
//
// Directed bench for spi_byte_slave. The master is modelled at clk/8 with all
// pin changes made on the falling edge of clk. A monitor counts ack_o pulses,
// back-to-back ack_o cycles and the cycle of the latest ack_o.
// -----------------------------------------------------------------------------
module tb_spi_byte_slave;

    localparam int SYNC = 2;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic [7:0] data;
    logic       ack;

    int n_assert;
    int n_fail;
    int cyc;
    int ack_cnt;
    int dbl_cnt;
    int ack_cyc;
    int rise_cyc;
    logic prev_ack;
    logic [7:0] miso_bits;
    int base;

    spi_byte_slave #(.SYNC_STAGES(SYNC)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .sclk_i    (sclk),
        .cs_ni     (cs_n),
        .mosi_i    (mosi),
        .miso_o    (miso),
        .tx_data_i (tx_data),
        .data_o    (data),
        .ack_o     (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ack === 1'b1) begin
            ack_cnt = ack_cnt + 1;
            ack_cyc = cyc;
            if (prev_ack === 1'b1) dbl_cnt = dbl_cnt + 1;
        end
        prev_ack = ack;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert = n_assert + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send the first n bits of b MSB first; MISO sampled at each pin-level rise.
    task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] mb);
        mb = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            rise_cyc = cyc;
            mb[7-i] = miso;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_start();
        @(negedge clk);
        cs_n = 1'b0;
    endtask

    task automatic frame_end();
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        n_assert = 0; n_fail = 0; cyc = 0; ack_cnt = 0; dbl_cnt = 0;
        ack_cyc = 0; rise_cyc = 0; prev_ack = 1'b0;
        rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_data = 8'h5A;
        repeat (4) @(negedge clk);
        check("reset_data", {24'd0, data}, 32'h00);
        check("reset_ack", {31'd0, ack}, 32'h0);
        check("reset_miso", {31'd0, miso}, 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single byte A5 with MISO returning 5A-loaded shifter (master sends A5).
        frame_start();
        send_bits(8'hA5, 8, miso_bits);
        frame_end();
        check("a5_ack_count", ack_cnt, 32'd1);
        check("a5_data", {24'd0, data}, 32'hA5);
        check("a5_latency_window",
              {31'd0, ((ack_cyc - rise_cyc) >= SYNC + 1) && ((ack_cyc - rise_cyc) <= SYNC + 2)},
              32'h1);

        // MISO: master sends 00, expect 5A shifted out (or 0 without the transmitter).
        frame_start();
        send_bits(8'h00, 8, miso_bits);
        frame_end();
`ifdef SPI_SLAVE_MISO_EN
        check("miso_5a", {24'd0, miso_bits}, 32'h5A);
`else
        check("miso_off", {24'd0, miso_bits}, 32'h00);
`endif
        check("miso_frame_ack", ack_cnt, 32'd2);
        check("miso_frame_data", {24'd0, data}, 32'h00);
        check("idle_miso_low", {31'd0, miso}, 32'h0);

        // Back-to-back bytes 3C, C3 in one frame.
        frame_start();
        send_bits(8'h3C, 8, miso_bits);
        repeat (2) @(negedge clk);
        check("b2b_first_ack", ack_cnt, 32'd3);
        check("b2b_first_data", {24'd0, data}, 32'h3C);
        send_bits(8'hC3, 8, miso_bits);
`ifdef SPI_SLAVE_MISO_EN
        check("b2b_second_miso", {24'd0, miso_bits}, 32'h5A);
`endif
        frame_end();
        check("b2b_second_ack", ack_cnt, 32'd4);
        check("b2b_second_data", {24'd0, data}, 32'hC3);

        // Partial byte (5 bits of FF) aborted, then full 12.
        frame_start();
        send_bits(8'hFF, 5, miso_bits);
        frame_end();
        check("partial_no_ack", ack_cnt, 32'd4);
        check("partial_data_held", {24'd0, data}, 32'hC3);
        frame_start();
        send_bits(8'h12, 8, miso_bits);
        frame_end();
        check("after_partial_ack", ack_cnt, 32'd5);
        check("after_partial_data", {24'd0, data}, 32'h12);

        // Reset after 4 bits, then frame 81.
        frame_start();
        send_bits(8'hF0, 4, miso_bits);
        rst_n = 1'b0;
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_data", {24'd0, data}, 32'h00);
        check("midreset_ack", {31'd0, ack}, 32'h0);
        check("midreset_miso", {31'd0, miso}, 32'h0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("postreset_no_ack", ack_cnt, 32'd5);
        frame_start();
        send_bits(8'h81, 8, miso_bits);
        frame_end();
        check("postreset_ack", ack_cnt, 32'd6);
        check("postreset_data", {24'd0, data}, 32'h81);

        // sclk toggling while deselected must be ignored.
        base = ack_cnt;
        send_bits(8'hFF, 8, miso_bits);
        repeat (8) @(negedge clk);
        check("idle_toggle_no_ack", ack_cnt - base, 32'd0);
        check("idle_toggle_data", {24'd0, data}, 32'h81);
        check("idle_toggle_miso", {24'd0, miso_bits}, 32'h00);

        check("no_double_ack", dbl_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
